fa_window_acc: RTL and testbench



---
 rtl/fa_window_acc.sv | 125 ++++++++++++
 tb/tb_fa_window_acc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fa_window_acc.sv
// fa_window_acc
//   Accumulates the registered {carry,sum} word of the full-adder stage over a
//   window of WINDOW valid samples. Presents the window total on a
//   valid/ready output handshake.
//
// Parameters:
//   WINDOW - valid input samples per window (>= 2)
//   SUM_W  - accumulator/output width (>= 2). Totals above 2^SUM_W-1 saturate.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-low reset
//   start     - begin a new window (taken in IDLE, or in DONE with sum_ready)
//   y_in      - adder output word {carry,sum}, unsigned 0..3
//   y_valid   - qualifies y_in; samples are accepted only while accumulating
//   sum_out   - window total, stable while sum_valid is high
//   sum_valid - window result available
//   sum_ready - downstream accepts the result
//   busy      - high while accumulating or holding a result
//   sat       - the reported window saturated; valid with sum_valid
module fa_window_acc #(
  parameter int WINDOW = 16,
  parameter int SUM_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       y_in,
  input  logic             y_valid,
  output logic [SUM_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy,
  output logic             sat
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat_flag;

  // One extra bit catches overflow: acc <= 2^SUM_W-1 and y_in <= 3, so the
  // sum never reaches 2^(SUM_W+1) and the top bit alone flags "exceeds max".
  logic [SUM_W:0]   add_full;
  logic             add_ovf;
  logic [SUM_W-1:0] add_sat;

  assign add_full = {1'b0, acc} + (SUM_W + 1)'(y_in);
  assign add_ovf  = add_full[SUM_W];
  assign add_sat  = add_ovf ? {SUM_W{1'b1}} : add_full[SUM_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
            busy     <= 1'b1;
          end
        end

        ACCUM: begin
          if (y_valid) begin
            acc      <= add_sat;
            cnt      <= cnt + 1'b1;
            sat_flag <= sat_flag | add_ovf;
            // The window closes on the WINDOW-th accepted sample, so cnt
            // never wraps.
            if (cnt == LAST) begin
              state     <= DONE;
              sum_out   <= add_sat;
              sat       <= sat_flag | add_ovf;
              sum_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          // Incoming samples are dropped while the result waits.
          if (sum_ready) begin
            sum_valid <= 1'b0;
            if (start) begin
              // Back-to-back window: restart without passing through IDLE.
              state    <= ACCUM;
              acc      <= '0;
              cnt      <= '0;
              sat_flag <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          sum_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_window_acc.sv
// tb_fa_window_acc
//   Self-checking bench for fa_window_acc. Two instances share one set of
//   inputs: one wide enough never to saturate (WINDOW=4, SUM_W=6) and one that
//   saturates easily (WINDOW=4, SUM_W=3). A window-level model tracks the
//   accepted samples and derives each expected total as the clipped plain sum.
module tb_fa_window_acc;

  localparam int W     = 4;
  localparam int MAX_A = 63;
  localparam int MAX_B = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] y_in = 2'd0;
  logic       y_valid = 1'b0;
  logic       sum_ready = 1'b0;

  logic [5:0] sum_a;
  logic       valid_a, busy_a, sat_a;
  logic [2:0] sum_b;
  logic       valid_b, busy_b, sat_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fa_window_acc #(.WINDOW(W), .SUM_W(6)) dut_a (
    .clk(clk), .reset(reset), .start(start), .y_in(y_in), .y_valid(y_valid),
    .sum_out(sum_a), .sum_valid(valid_a), .sum_ready(sum_ready),
    .busy(busy_a), .sat(sat_a)
  );

  fa_window_acc #(.WINDOW(W), .SUM_W(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .y_in(y_in), .y_valid(y_valid),
    .sum_out(sum_b), .sum_valid(valid_b), .sum_ready(sum_ready),
    .busy(busy_b), .sat(sat_b)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Window-level model: phase 0 = waiting for start, 1 = collecting samples,
  // 2 = result offered. Totals are plain sums clipped to each instance's max.
  int phase = 0;
  int samples[$];
  bit exp_busy = 1'b0;
  bit exp_valid = 1'b0;
  int exp_sum_a = 0;
  int exp_sum_b = 0;
  bit exp_sat_a = 1'b0;
  bit exp_sat_b = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= 0;
      samples.delete();
      exp_busy  <= 1'b0;
      exp_valid <= 1'b0;
      exp_sum_a <= 0;
      exp_sum_b <= 0;
      exp_sat_a <= 1'b0;
      exp_sat_b <= 1'b0;
    end else begin
      case (phase)
        0: if (start) begin
          samples.delete();
          phase    <= 1;
          exp_busy <= 1'b1;
        end
        1: if (y_valid) begin
          samples.push_back(int'(y_in));
          if (samples.size() == W) begin
            int total;
            total = 0;
            foreach (samples[k]) total += samples[k];
            exp_sum_a <= (total > MAX_A) ? MAX_A : total;
            exp_sat_a <= (total > MAX_A);
            exp_sum_b <= (total > MAX_B) ? MAX_B : total;
            exp_sat_b <= (total > MAX_B);
            exp_valid <= 1'b1;
            phase     <= 2;
          end
        end
        default: if (sum_ready) begin
          exp_valid <= 1'b0;
          if (start) begin
            samples.delete();
            phase <= 1;
          end else begin
            phase    <= 0;
            exp_busy <= 1'b0;
          end
        end
      endcase
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy_a", busy_a, exp_busy);
    check("busy_b", busy_b, exp_busy);
    check("valid_a", valid_a, exp_valid);
    check("valid_b", valid_b, exp_valid);
    if (exp_valid) begin
      check("sum_a", sum_a, exp_sum_a);
      check("sat_a", sat_a, exp_sat_a);
      check("sum_b", sum_b, exp_sum_b);
      check("sat_b", sat_b, exp_sat_b);
    end
  end

  // Drive one cycle's inputs, let the edge pass, return 1 time unit after it.
  task automatic apply_stimulus(input bit s, input bit v, input logic [1:0] y,
                                input bit r);
    start     = s;
    y_valid   = v;
    y_in      = y;
    sum_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [1:0] y, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b1, y, 1'b0);
  endtask

  initial begin
    $display("[TB] start");

    // Reset held with random inputs: everything stays cleared.
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
    check("rst_sum", sum_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_sat", sat_a, 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
    check("idle_busy", busy_a, 0);
    check("idle_valid", valid_a, 0);

    // Basic window 1,2,3,0.
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    check("basic_busy", busy_a, 1);
    apply_stimulus(1'b0, 1'b1, 2'd1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2'd2, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2'd3, 1'b0);
    check("basic_early", valid_a, 0);
    apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
    check("basic_valid", valid_a, 1);
    check("basic_sum", sum_a, 6);
    check("basic_sat", sat_a, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 2'd3, 1'b0);
    check("basic_hold", sum_a, 6);
    check("basic_hold_v", valid_a, 1);
    apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);
    check("basic_release", valid_a, 0);
    check("basic_idle", busy_a, 0);

    // Gapped input: y_in=3 present throughout, only every other cycle valid.
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, (i % 2) == 0, 2'd3, 1'b0);
      if (i == 5) check("gap_early", valid_a, 0);
      if (i == 6) begin
        check("gap_sum_a", sum_a, 12);
        check("gap_sum_b", sum_b, 7);
        check("gap_sat_b", sat_b, 1);
      end
    end
    apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);

    // Saturation, then a clean window clears the sticky flag.
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    feed(2'd3, 4);
    check("sat_sum_b", sum_b, 7);
    check("sat_flag_b", sat_b, 1);
    check("sat_sat_a", sat_a, 0);
    apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    feed(2'd1, 4);
    check("unsat_sum_b", sum_b, 4);
    check("unsat_flag_b", sat_b, 0);

    // Back-to-back: ready and start together, plus a sample offered in DONE.
    apply_stimulus(1'b1, 1'b1, 2'd3, 1'b1);
    check("b2b_busy", busy_a, 1);
    check("b2b_valid", valid_a, 0);
    feed(2'd2, 4);
    check("b2b_sum", sum_a, 8);
    apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);

    // Asynchronous reset between edges after two samples.
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    feed(2'd3, 2);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy_a, 0);
    check("arst_valid", valid_a, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    apply_stimulus(1'b0, 1'b1, 2'd3, 1'b0);
    check("arst_stay_idle", busy_a, 0);
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    feed(2'd1, 4);
    check("arst_sum", sum_a, 4);
    apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                     2'($urandom), $urandom_range(0, 2) == 0);

    // Occasional random asynchronous resets under random traffic.
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 30; i++)
        apply_stimulus($urandom_range(0, 2) == 0, 1'($urandom),
                       2'($urandom), 1'($urandom));
      #3 reset = 1'b0;
      #1;
      check("rnd_arst_busy", busy_b, 0);
      @(posedge clk);
      #1 reset = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
